// File: rtl/icache_mem_responder.sv
// ============================================================================
// Module   : icache_mem_responder
// Function : Memory-side refill responder for the L1 icache. It accepts one
//            request, reads a line (or a single word) from a fixed-latency
//            RAM and returns the line with a one-cycle dataOK pulse.
// Options  : MEM_RESP_LFSR_STALL_EN - LFSR-driven pseudo-random stalls on
//            addrOK and dataOK.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module icache_mem_responder #(
    parameter int OFFSET_W = 2,
    parameter int RAM_AW   = 16,
    parameter int RAM_LAT  = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          icache_mem_req,
    input  logic [31:0]                   icache_mem_addr,
    input  logic [1:0]                    icache_mem_size,
    output logic                          mem_icache_addrOK,
    output logic                          mem_icache_dataOK,
    output logic [32*(2**OFFSET_W)-1:0]   mem_icache_data,
    output logic                          ram_en,
    output logic [RAM_AW-1:0]             ram_addr,
    input  logic [31:0]                   ram_rdata
);

    localparam int WORDS  = 2**OFFSET_W;
    localparam int CNT_W  = OFFSET_W + 1;
    localparam int LINE_W = 32 * WORDS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_READ = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [RAM_AW-1:0]    addr_q,      addr_d;
    logic                 line_mode_q, line_mode_d;
    logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]     ret_cnt_q,   ret_cnt_d;
    logic [RAM_LAT-1:0]   vld_q,       vld_d;
    logic [LINE_W-1:0]    line_q,      line_d;

    logic [CNT_W-1:0]     w_num_reads;
    logic [OFFSET_W+4:0]  w_ret_bit;
    logic                 w_ack_go;
    logic                 w_resp_go;

    // Only the word-address bits inside the RAM window are meaningful.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{icache_mem_addr[31:RAM_AW+2], icache_mem_addr[1:0]};

`ifdef MEM_RESP_LFSR_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci form of x^8+x^6+x^5+x^4+1, stepping every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_ack_go  = ~lfsr_q[0];
    assign w_resp_go = ~lfsr_q[1];
`else
    assign w_ack_go  = 1'b1;
    assign w_resp_go = 1'b1;
`endif

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        line_mode_d       = line_mode_q;
        issue_cnt_d       = issue_cnt_q;
        ret_cnt_d         = ret_cnt_q;
        line_d            = line_q;
        vld_d             = '0;
        mem_icache_addrOK = 1'b0;
        mem_icache_dataOK = 1'b0;
        ram_en            = 1'b0;
        ram_addr          = '0;
        w_num_reads       = line_mode_q ? CNT_W'(WORDS) : CNT_W'(1);
        w_ret_bit         = {ret_cnt_q[OFFSET_W-1:0], 5'd0};

        case (state_q)
            S_IDLE: begin
                if (icache_mem_req) begin
                    addr_d      = icache_mem_addr[RAM_AW+1:2];
                    line_mode_d = (icache_mem_size == 2'd2);
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = S_ACK;
                end
            end

            S_ACK: begin
                if (w_ack_go) begin
                    mem_icache_addrOK = 1'b1;
                    state_d           = S_READ;
                end
            end

            S_READ: begin
                if (issue_cnt_q < w_num_reads) begin
                    ram_en      = 1'b1;
                    ram_addr    = line_mode_q ?
                                  {addr_q[RAM_AW-1:OFFSET_W], issue_cnt_q[OFFSET_W-1:0]} :
                                  addr_q;
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (vld_q[RAM_LAT-1]) begin
                    // The previous line stays visible until this request's first word lands.
                    if (ret_cnt_q == '0) begin
                        line_d = '0;
                    end
                    line_d[w_ret_bit +: 32] = ram_rdata;
                    ret_cnt_d               = ret_cnt_q + CNT_W'(1);
                    if (ret_cnt_q == w_num_reads - CNT_W'(1)) begin
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                if (w_resp_go) begin
                    mem_icache_dataOK = 1'b1;
                    state_d           = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        vld_d[0] = ram_en;
        for (int i = 1; i < RAM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            line_mode_q <= 1'b0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            vld_q       <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            line_mode_q <= line_mode_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            vld_q       <= vld_d;
            line_q      <= line_d;
        end
    end

    assign mem_icache_data = line_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_mem_responder.sv
// ============================================================================
// Module   : tb_icache_mem_responder
// Function : Self-checking bench for icache_mem_responder (directed table,
//            reset corner case, randomized refills against a line model).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_icache_mem_responder;

    localparam int OFFSET_W = 2;
    localparam int RAM_AW   = 16;
    localparam int RAM_LAT  = 1;
    localparam int WORDS    = 2**OFFSET_W;
    localparam int LW       = 32 * WORDS;

    logic              clk  = 1'b0;
    logic              rstn = 1'b0;
    logic              req  = 1'b0;
    logic [31:0]       addr = '0;
    logic [1:0]        size = '0;
    logic              addr_ok;
    logic              data_ok;
    logic [LW-1:0]     line;
    logic              ram_en;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_rdata;

    always #5 clk = ~clk;

    icache_mem_responder #(
        .OFFSET_W (OFFSET_W),
        .RAM_AW   (RAM_AW),
        .RAM_LAT  (RAM_LAT)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .icache_mem_req    (req),
        .icache_mem_addr   (addr),
        .icache_mem_size   (size),
        .mem_icache_addrOK (addr_ok),
        .mem_icache_dataOK (data_ok),
        .mem_icache_data   (line),
        .ram_en            (ram_en),
        .ram_addr          (ram_addr),
        .ram_rdata         (ram_rdata)
    );

    // Backing RAM: word i holds C0DE0000+i, returned RAM_LAT cycles after the read.
    logic [31:0] rpipe [RAM_LAT];
    always @(posedge clk) begin
        rpipe[0] <= 32'hC0DE0000 + 32'(ram_addr);
        for (int i = 1; i < RAM_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata = rpipe[RAM_LAT-1];

    int            errors = 0;
    int            checks = 0;
    logic [LW-1:0] prev_line;
    bit            prev_valid = 0;
    bit            prev_hold  = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] model_line(input logic [31:0] a, input logic [1:0] s);
        int unsigned   idx;
        int unsigned   base;
        logic [LW-1:0] r;
        idx  = (a >> 2) % (32'd1 << RAM_AW);
        base = idx - (idx % WORDS);
        r    = '0;
        if (s == 2'd2) begin
            for (int k = 0; k < WORDS; k++) r[32*k +: 32] = 32'hC0DE0000 + base + k;
        end else begin
            r[31:0] = 32'hC0DE0000 + idx;
        end
        return r;
    endfunction

    function automatic int model_first_ra(input logic [31:0] a, input logic [1:0] s);
        int unsigned idx;
        idx = (a >> 2) % (32'd1 << RAM_AW);
        return (s == 2'd2) ? int'(idx - (idx % WORDS)) : int'(idx);
    endfunction

    task automatic do_gap(input int n);
        repeat (n) @(negedge clk);
        if (prev_valid) chk("data_hold", 160'(line), 160'(prev_line));
    endtask

    // Starts at a negedge; lag=1 when that negedge falls in the previous RESP cycle.
    task automatic run_txn(input logic [31:0] a, input logic [1:0] s, input logic hold,
                           input int lag, input logic [LW-1:0] exp_data,
                           input int first_ra, input int nrd);
        int                n_ack = 0;
        int                n_dok = 0;
        int                ack_c = -1;
        int                dok_c = -1;
        logic [LW-1:0]     got   = '0;
        logic [RAM_AW-1:0] q[$];
        bit                seq_ok;
        req  = 1'b1;
        addr = a;
        size = s;
        for (int c = 1; c <= 300 && dok_c < 0; c++) begin
            @(negedge clk);
            if (!hold && c > lag) req = 1'b0;
            if (ram_en) q.push_back(ram_addr);
            if (addr_ok) begin
                n_ack++;
                if (ack_c < 0) ack_c = c;
            end
            if (data_ok) begin
                n_dok++;
                dok_c = c;
                got   = line;
            end
        end
        req = 1'b0;
        chk("dataOK_arrived", 160'(dok_c >= 0), 160'(1));
        chk("addrOK_count", 160'(n_ack), 160'(1));
        chk("dataOK_count", 160'(n_dok), 160'(1));
        chk("line_data", 160'(got), 160'(exp_data));
        chk("ram_read_count", 160'(q.size()), 160'(nrd));
        seq_ok = (q.size() == nrd);
        for (int k = 0; k < q.size(); k++)
            if (q[k] != RAM_AW'(first_ra + k)) seq_ok = 0;
        chk("ram_addr_seq", 160'(seq_ok), 160'(1));
`ifndef MEM_RESP_LFSR_STALL_EN
        chk("addrOK_latency", 160'(ack_c), 160'(1 + lag));
        chk("dataOK_latency", 160'(dok_c), 160'(lag + 1 + nrd + RAM_LAT + 1));
`endif
        prev_line  = exp_data;
        prev_valid = 1;
        prev_hold  = hold;
    endtask

    typedef struct {
        logic [31:0]   a;
        logic [1:0]    s;
        logic          hold;
        int            lag;
        logic [LW-1:0] data;
        int            first_ra;
        int            nrd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int            quiet;
        logic [31:0]   ra;
        logic [1:0]    rs;
        logic          rh;

        vecs[0] = '{32'h0000_0040, 2'd2, 1'b0, 0,
                    {32'hC0DE0013, 32'hC0DE0012, 32'hC0DE0011, 32'hC0DE0010}, 16, 4};
        vecs[1] = '{32'h0000_004C, 2'd2, 1'b0, 0,
                    {32'hC0DE0013, 32'hC0DE0012, 32'hC0DE0011, 32'hC0DE0010}, 16, 4};
        vecs[2] = '{32'h0000_0048, 2'd0, 1'b0, 0, {96'h0, 32'hC0DE0012}, 18, 1};
        vecs[3] = '{32'h0000_0040, 2'd2, 1'b1, 0,
                    {32'hC0DE0013, 32'hC0DE0012, 32'hC0DE0011, 32'hC0DE0010}, 16, 4};
        vecs[4] = '{32'h0000_0044, 2'd1, 1'b0, 1, {96'h0, 32'hC0DE0011}, 17, 1};
        vecs[5] = '{32'h0004_0040, 2'd2, 1'b0, 0,
                    {32'hC0DE0013, 32'hC0DE0012, 32'hC0DE0011, 32'hC0DE0010}, 16, 4};
        vecs[6] = '{32'h0003_FFF8, 2'd2, 1'b0, 0,
                    {32'hC0DEFFFF, 32'hC0DEFFFE, 32'hC0DEFFFD, 32'hC0DEFFFC}, 16'hFFFC, 4};
        vecs[7] = '{32'hFFFF_FFFF, 2'd1, 1'b0, 0, {96'h0, 32'hC0DEFFFF}, 16'hFFFF, 1};
        vecs[8] = '{32'h0000_0010, 2'd3, 1'b0, 0, {96'h0, 32'hC0DE0004}, 4, 1};

        repeat (2) @(negedge clk);
        chk("reset_outputs", 160'({addr_ok, data_ok, ram_en, ram_addr, line}), 160'(0));
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].lag == 0) do_gap(1);
            run_txn(vecs[i].a, vecs[i].s, vecs[i].hold, vecs[i].lag,
                    vecs[i].data, vecs[i].first_ra, vecs[i].nrd);
        end

        // Reset while the line is being read.
        do_gap(1);
        req  = 1'b1;
        addr = 32'h0000_0080;
        size = 2'd2;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
`ifndef MEM_RESP_LFSR_STALL_EN
        chk("read_active_before_reset", 160'(ram_en), 160'(1));
`endif
        rstn = 1'b0;
        @(negedge clk);
        chk("reset_mid_read", 160'({addr_ok, data_ok, ram_en, ram_addr, line}), 160'(0));
        rstn  = 1'b1;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (addr_ok || data_ok) quiet++;
        end
        chk("no_response_after_reset", 160'(quiet), 160'(0));
        prev_line  = '0;
        prev_valid = 1;
        prev_hold  = 0;

        for (int n = 0; n < 100; n++) begin
            ra = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'd2;
            rh = ($urandom_range(0, 7) == 0);
            if (!prev_hold) do_gap($urandom_range(1, 3));
            run_txn(ra, rs, rh, prev_hold ? 1 : 0, model_line(ra, rs),
                    model_first_ra(ra, rs), (rs == 2'd2) ? WORDS : 1);
        end

        do_gap(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
